// File: rtl/jtag_pkg.sv
// Shared types and constants for the IEEE 1149.1 TAP controller.
// JTAG_IDCODE_EN selects whether the 32-bit IDCODE register exists (and the IR reset value).
package jtag_pkg;

    localparam int unsigned IR_W = 4;

    localparam logic [IR_W-1:0] OP_EXTEST = 4'b0000;
    localparam logic [IR_W-1:0] OP_SAMPLE = 4'b0001;
    localparam logic [IR_W-1:0] OP_IDCODE = 4'b0010;
    localparam logic [IR_W-1:0] OP_BYPASS = 4'b1111;

    localparam logic [31:0] IDCODE_VAL = 32'h1000_563F;

    // Fixed pattern loaded in Capture-IR; the trailing 01 lets a host find the IR boundary.
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

`ifdef JTAG_IDCODE_EN
    localparam logic [IR_W-1:0] IR_RST = OP_IDCODE;
`else
    localparam logic [IR_W-1:0] IR_RST = OP_BYPASS;
`endif

    typedef enum logic [3:0] {
        StTlr     = 4'hF,
        StRti     = 4'hC,
        StSelDr   = 4'h7,
        StCapDr   = 4'h6,
        StShDr    = 4'h2,
        StEx1Dr   = 4'h1,
        StPauseDr = 4'h3,
        StEx2Dr   = 4'h0,
        StUpdDr   = 4'h5,
        StSelIr   = 4'h4,
        StCapIr   = 4'hE,
        StShIr    = 4'hA,
        StEx1Ir   = 4'h9,
        StPauseIr = 4'hB,
        StEx2Ir   = 4'h8,
        StUpdIr   = 4'hD
    } tap_state_e;

    typedef enum logic [1:0] {
        SelBsr,
        SelBypass,
        SelIdcode
    } dr_sel_e;

    // Unlisted opcodes (and IDCODE when the register is absent) fall back to BYPASS.
    function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
        if (ir == OP_EXTEST || ir == OP_SAMPLE) begin
            return SelBsr;
        end
`ifdef JTAG_IDCODE_EN
        if (ir == OP_IDCODE) begin
            return SelIdcode;
        end
`endif
        return SelBypass;
    endfunction

endpackage

// File: rtl/jtag_tap_ctrl_if.sv
// Pin bundle between the TAP controller and its tester/boundary-chain environment.
// The controller uses the slave modport; the driving side uses master.
interface jtag_tap_ctrl_if;

    logic       TMS;
    logic       TDI;
    logic       bsr_so;
    logic       TDO;
    logic       TDO_en;
    logic       bsr_si;
    logic       shiftDR;
    logic       clockDR;
    logic       updateDR;
    logic       mode;
    logic [3:0] tap_state;

    modport slave (
        input  TMS, TDI, bsr_so,
        output TDO, TDO_en, bsr_si, shiftDR, clockDR, updateDR, mode, tap_state
    );

    modport master (
        output TMS, TDI, bsr_so,
        input  TDO, TDO_en, bsr_si, shiftDR, clockDR, updateDR, mode, tap_state
    );

endinterface

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP state machine: state register plus TMS-driven next-state logic.
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic       TCK,
    input  logic       TRST_n,
    input  logic       tms_i,
    output tap_state_e state_o
);

    tap_state_e state_q, state_d;

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            state_q <= StTlr;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:     state_d = tms_i ? StTlr     : StRti;
            StRti:     state_d = tms_i ? StSelDr   : StRti;
            StSelDr:   state_d = tms_i ? StSelIr   : StCapDr;
            StCapDr:   state_d = tms_i ? StEx1Dr   : StShDr;
            StShDr:    state_d = tms_i ? StEx1Dr   : StShDr;
            StEx1Dr:   state_d = tms_i ? StUpdDr   : StPauseDr;
            StPauseDr: state_d = tms_i ? StEx2Dr   : StPauseDr;
            StEx2Dr:   state_d = tms_i ? StUpdDr   : StShDr;
            StUpdDr:   state_d = tms_i ? StSelDr   : StRti;
            StSelIr:   state_d = tms_i ? StTlr     : StCapIr;
            StCapIr:   state_d = tms_i ? StEx1Ir   : StShIr;
            StShIr:    state_d = tms_i ? StEx1Ir   : StShIr;
            StEx1Ir:   state_d = tms_i ? StUpdIr   : StPauseIr;
            StPauseIr: state_d = tms_i ? StEx2Ir   : StPauseIr;
            StEx2Ir:   state_d = tms_i ? StUpdIr   : StShIr;
            StUpdIr:   state_d = tms_i ? StSelDr   : StRti;
            default:   state_d = StTlr;
        endcase
    end

    always_comb begin
        state_o = state_q;
    end

endmodule

// File: rtl/jtag_tap_ctrl.sv
// TAP controller top: IR, bypass/IDCODE registers, boundary-cell clock gating and TDO mux.
// JTAG_IDCODE_EN adds the IDCODE data register.
module jtag_tap_ctrl
    import jtag_pkg::*;
(
    input  logic           TCK,
    input  logic           TRST_n,
    jtag_tap_ctrl_if.slave bus
);

    tap_state_e      state;
    dr_sel_e         sel;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic [IR_W-1:0] ir_q, ir_d;
    logic            bypass_q, bypass_d;
    logic            clkdr_en_q, clkdr_en_d;
    logic            tdo_q, tdo_d;
    logic            tdo_en_q, tdo_en_d;
    logic            idcode_lsb;

    jtag_tap_fsm u_fsm (
        .TCK     (TCK),
        .TRST_n  (TRST_n),
        .tms_i   (bus.TMS),
        .state_o (state)
    );

    assign sel = decode_ir(ir_q);

    // IR shift stage (rising edge).
    always_comb begin
        ir_sr_d = ir_sr_q;
        if (state == StCapIr) begin
            ir_sr_d = IR_CAPTURE;
        end else if (state == StShIr) begin
            ir_sr_d = {bus.TDI, ir_sr_q[IR_W-1:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_sr_q <= IR_CAPTURE;
        end else begin
            ir_sr_q <= ir_sr_d;
        end
    end

    // Active IR moves on the falling edge so decoded controls never change while TCK is high.
    always_comb begin
        ir_d = ir_q;
        if (state == StTlr) begin
            ir_d = IR_RST;
        end else if (state == StUpdIr) begin
            ir_d = ir_sr_q;
        end
    end

    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            ir_q <= IR_RST;
        end else begin
            ir_q <= ir_d;
        end
    end

    always_comb begin
        bypass_d = bypass_q;
        if (state == StCapDr) begin
            bypass_d = 1'b0;
        end else if (state == StShDr && sel == SelBypass) begin
            bypass_d = bus.TDI;
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            bypass_q <= 1'b0;
        end else begin
            bypass_q <= bypass_d;
        end
    end

`ifdef JTAG_IDCODE_EN
    logic [31:0] idcode_q, idcode_d;

    always_comb begin
        idcode_d = idcode_q;
        if (state == StCapDr) begin
            idcode_d = IDCODE_VAL;
        end else if (state == StShDr && sel == SelIdcode) begin
            idcode_d = {bus.TDI, idcode_q[31:1]};
        end
    end

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            idcode_q <= IDCODE_VAL;
        end else begin
            idcode_q <= idcode_d;
        end
    end

    assign idcode_lsb = idcode_q[0];
`else
    assign idcode_lsb = 1'b0;
`endif

    // Enable is sampled while TCK is low, so TCK & enable cannot glitch.
    assign clkdr_en_d = (state == StCapDr || state == StShDr) && (sel == SelBsr);

    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            clkdr_en_q <= 1'b0;
        end else begin
            clkdr_en_q <= clkdr_en_d;
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state == StShIr) begin
            tdo_en_d = 1'b1;
            tdo_d    = ir_sr_q[0];
        end else if (state == StShDr) begin
            tdo_en_d = 1'b1;
            case (sel)
                SelBsr:    tdo_d = bus.bsr_so;
                SelIdcode: tdo_d = idcode_lsb;
                default:   tdo_d = bypass_q;
            endcase
        end
    end

    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign bus.TDO       = tdo_q;
    assign bus.TDO_en    = tdo_en_q;
    assign bus.bsr_si    = bus.TDI;
    assign bus.shiftDR   = (state == StShDr) && (sel == SelBsr);
    assign bus.clockDR   = TCK & clkdr_en_q;
    assign bus.updateDR  = ~TCK & (state == StUpdDr) & (sel == SelBsr);
    assign bus.mode      = (ir_q == OP_EXTEST);
    assign bus.tap_state = state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: expected TDO bits are queued as TMS/TDI are driven
// and popped whenever the DUT drives TDO_en. Works with or without JTAG_IDCODE_EN.
module tb_jtag_tap_ctrl;
    import jtag_pkg::*;

    localparam int KBsr = 0;
    localparam int KByp = 1;
    localparam int KId  = 2;
`ifdef JTAG_IDCODE_EN
    localparam int KRst = KId;
`else
    localparam int KRst = KByp;
`endif

    logic TCK    = 1'b0;
    logic TRST_n = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned n_clkdr  = 0;
    int unsigned n_upddr  = 0;
    logic        exp_q[$];
    logic        bsr_mode = 1'b0;
    logic        cur_mode = 1'b0;
    logic        mode_hi  = 1'b0;

    jtag_tap_ctrl_if bus ();

    jtag_tap_ctrl dut (
        .TCK    (TCK),
        .TRST_n (TRST_n),
        .bus    (bus)
    );

    initial forever #5 TCK = ~TCK;

    always @(posedge bus.clockDR) n_clkdr++;
    always @(posedge bus.updateDR) n_upddr++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // TDO was launched on the previous falling edge; sample it on the rising edge.
    always @(posedge TCK) begin
        if (TRST_n && bus.TDO_en === 1'b1) begin
            if (exp_q.size() == 0) check_eq("tdo_unexpected", bus.TDO_en, 1'b0);
            else check_eq("tdo", bus.TDO, exp_q.pop_front());
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic tms, input logic tdi, input logic bso, input tap_state_e st,
                        input logic exp_tdo);
        logic shifting;
        shifting   = (st == StShDr) || (st == StShIr);
        bus.TMS    = tms;
        bus.TDI    = tdi;
        bus.bsr_so = bso;
        if (shifting) exp_q.push_back(exp_tdo);
        @(posedge TCK);
        #1;
        check_eq("tap_state", bus.tap_state, st);
        check_eq("shiftDR", bus.shiftDR, (st == StShDr) && bsr_mode);
        check_eq("bsr_si", bus.bsr_si, tdi);
        mode_hi = bus.mode;
        @(negedge TCK);
        #1;
        check_eq("tdo_en", bus.TDO_en, shifting);
        if (!shifting) check_eq("tdo_idle", bus.TDO, 1'b0);
    endtask

    task automatic load_ir(input logic [IR_W-1:0] op);
        logic [IR_W-1:0] cap;
        logic [IR_W-1:0] sh;
        logic            last;
        logic            exp_mode;
        cap = IR_CAPTURE;
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StSelIr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapIr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StShIr, cap[0]);
        for (int i = 0; i < IR_W; i++) begin
            last = (i == IR_W - 1);
            sh   = cap >> (i + 1);
            step(last, op[i], 1'b0, last ? StEx1Ir : StShIr, sh[0]);
        end
        exp_mode = (op == OP_EXTEST);
        step(1'b1, 1'b0, 1'b0, StUpdIr, 1'b0);
        check_eq("mode_before_upd_fall", mode_hi, cur_mode);
        check_eq("mode_after_upd_fall", bus.mode, exp_mode);
        cur_mode = exp_mode;
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);
        bsr_mode = (op == OP_EXTEST) || (op == OP_SAMPLE);
    endtask

    task automatic shift_dr(input int n, input logic [31:0] data, input int kind);
        logic [31:0] id;
        logic [31:0] sh;
        int unsigned c0;
        int unsigned u0;
        logic        bso;
        logic        last;
        logic        e;
        id = IDCODE_VAL;
        c0 = n_clkdr;
        u0 = n_upddr;
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapDr, 1'b0);
        bso = 1'($urandom_range(1, 0));
        e   = (kind == KBsr) ? bso : (kind == KId) ? id[0] : 1'b0;
        step(1'b0, 1'b0, bso, StShDr, e);
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1);
            bso  = 1'($urandom_range(1, 0));
            sh   = id >> (i + 1);
            e    = (kind == KBsr) ? bso : (kind == KId) ? sh[0] : data[i];
            step(last, data[i], bso, last ? StEx1Dr : StShDr, e);
        end
        step(1'b1, 1'b0, 1'b0, StUpdDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);
        check_eq("clockDR_pulses", n_clkdr - c0, (kind == KBsr) ? n + 1 : 0);
        check_eq("updateDR_pulses", n_upddr - u0, (kind == KBsr) ? 1 : 0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.TMS    = 1'b0;
        bus.TDI    = 1'b0;
        bus.bsr_so = 1'b0;
        #12;
        check_eq("rst_state", bus.tap_state, StTlr);
        check_eq("rst_tdo_en", bus.TDO_en, 1'b0);
        check_eq("rst_tdo", bus.TDO, 1'b0);
        check_eq("rst_mode", bus.mode, 1'b0);
        check_eq("rst_shiftDR", bus.shiftDR, 1'b0);
        check_eq("rst_clockDR", bus.clockDR, 1'b0);
        @(negedge TCK);
        #1;
        TRST_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, StTlr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);

        // Reset instruction: IDCODE stream, or bypass when the register is absent.
        shift_dr(32, 32'hA5C3_0F96, KRst);

        // EXTEST, then five TMS=1 from PauseDR back to TLR reverts IR and mode.
        load_ir(OP_EXTEST);
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StEx1Dr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StPauseDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StEx2Dr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StUpdDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StSelIr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StTlr, 1'b0);
        check_eq("mode_after_tlr", bus.mode, 1'b0);
        cur_mode = 1'b0;
        bsr_mode = 1'b0;
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);

        load_ir(OP_SAMPLE);
        shift_dr(8, 32'hB3, KBsr);

        load_ir(OP_BYPASS);
        shift_dr(8, 32'hB3, KByp);

        // Unknown opcode acts as bypass; pause with TDI toggling must hold the bypass bit.
        load_ir(4'b0101);
        shift_dr(8, 32'h5C, KByp);
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StShDr, 1'b0);
        step(1'b0, 1'b1, 1'b0, StShDr, 1'b1);
        step(1'b1, 1'b1, 1'b0, StEx1Dr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StPauseDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StEx2Dr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StShDr, 1'b1);
        step(1'b1, 1'b0, 1'b0, StEx1Dr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StUpdDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);

        // Five TMS=1 from ShIR; passing UpdIR loads 0000 (EXTEST) before TLR clears it.
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StSelIr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapIr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StShIr, 1'b1);
        step(1'b1, 1'b0, 1'b0, StEx1Ir, 1'b0);
        step(1'b1, 1'b0, 1'b0, StUpdIr, 1'b0);
        check_eq("mode_shir_upd", bus.mode, 1'b1);
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StSelIr, 1'b0);
        step(1'b1, 1'b0, 1'b0, StTlr, 1'b0);
        check_eq("mode_shir_tlr", bus.mode, 1'b0);
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);

        // Reset in the middle of a SAMPLE shift while TCK is high.
        load_ir(OP_SAMPLE);
        step(1'b1, 1'b0, 1'b0, StSelDr, 1'b0);
        step(1'b0, 1'b0, 1'b0, StCapDr, 1'b0);
        step(1'b0, 1'b1, 1'b1, StShDr, 1'b1);
        step(1'b0, 1'b0, 1'b0, StShDr, 1'b0);
        @(posedge TCK);
        #2;
        TRST_n = 1'b0;
        #1;
        check_eq("midrst_state", bus.tap_state, StTlr);
        check_eq("midrst_tdo_en", bus.TDO_en, 1'b0);
        check_eq("midrst_tdo", bus.TDO, 1'b0);
        check_eq("midrst_mode", bus.mode, 1'b0);
        check_eq("midrst_shiftDR", bus.shiftDR, 1'b0);
        check_eq("midrst_clockDR", bus.clockDR, 1'b0);
        @(negedge TCK);
        #1;
        TRST_n   = 1'b1;
        bsr_mode = 1'b0;
        cur_mode = 1'b0;
        step(1'b0, 1'b0, 1'b0, StRti, 1'b0);
        shift_dr(32, 32'h3C96_5AF0, KRst);

        check_eq("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
